// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions.
// Frame marker, memory geometry and loader FSM states.
package imem_loader_pkg;

  localparam int DEPTH = 128;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    WRITE,
    GET_CSUM,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader byte stream interface.
// master = byte source, slave = loader.
interface imem_loader_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// imem_loader byte-to-word packer.
// Little-endian: first byte lands in bits 7:0.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last,
  output logic        complete
);

  logic [1:0] count;

  assign last = (count == 2'd3);

  // shift bytes in from the top, flag the 4th byte
  always_ff @(posedge clk) begin
    if (reset) begin
      word     <= '0;
      count    <= '0;
      complete <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      complete <= 1'b0;
    end else if (shift) begin
      word     <= {byte_in, word[31:8]};
      count    <= count + 2'd1;
      complete <= last;
    end else begin
      complete <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to instruction memory.
// Holds the core in reset until a checksummed program loads.
module imem_loader #(
  parameter int         DEPTH      = 128,
  parameter int         ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_loader_if.slave          rx,
  input  logic                  load_req,
  output logic                  mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  core_reset,
  output logic                  done,
  output logic                  err
);

  import imem_loader_pkg::*;

  state_t                state;
  state_t                state_n;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [7:0]            len_q;
  logic [7:0]            csum;
  logic [31:0]           word;
  logic                  last;
  logic                  complete;
  logic                  acc;
  logic                  last_word;
  logic                  bad_len;

  assign acc       = rx.rx_valid && rx.rx_ready;
  assign last_word = (int'(word_idx) == int'(len_q) - 1);
  assign bad_len   = (rx.rx_data == 8'd0)
                  || (int'(rx.rx_data) > DEPTH);
  assign mem_addr  = word_idx;
  assign mem_data  = word;

  word_packer u_pack (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state == GET_LEN && acc) || complete),
    .shift    (state == GET_DATA && acc),
    .byte_in  (rx.rx_data),
    .word     (word),
    .last     (last),
    .complete (complete)
  );

  // next state from current state and accepted byte
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (acc && rx.rx_data == SYNC_BYTE)
          state_n = GET_LEN;
      GET_LEN:
        if (acc)
          state_n = bad_len ? ERROR : GET_DATA;
      GET_DATA:
        if (acc && last)
          state_n = WRITE;
      WRITE:
        state_n = last_word ? GET_CSUM : GET_DATA;
      GET_CSUM:
        if (acc)
          state_n = (rx.rx_data == csum) ? DONE : ERROR;
      DONE, ERROR:
        if (load_req)
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // state, frame registers and outputs decoded from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_idx    <= '0;
      len_q       <= '0;
      csum        <= '0;
      rx.rx_ready <= 1'b0;
      mem_wren    <= 1'b0;
      core_reset  <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      rx.rx_ready <= (state_n == IDLE)
                  || (state_n == GET_LEN)
                  || (state_n == GET_DATA)
                  || (state_n == GET_CSUM);
      mem_wren    <= (state_n == WRITE);
      core_reset  <= (state_n != DONE);
      done        <= (state_n == DONE);
      err         <= (state_n == ERROR);
      if (state == GET_LEN && state_n == GET_DATA) begin
        len_q    <= rx.rx_data;
        word_idx <= '0;
        csum     <= '0;
      end
      if (state == GET_DATA && acc)
        csum <= csum ^ rx.rx_data;
      if (state == WRITE)
        word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, 128, number of 32-bit instruction words in the instruction memory.
REQ-002 Parameter ADDR_WIDTH, $clog2(DEPTH) = 7, word-address width.
REQ-003 Parameter SYNC_BYTE, 8'hA5, frame start marker.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 rx_valid  input  1  byte source has a byte on rx_data.
REQ-007 rx_data  input  8  incoming byte.
REQ-008 rx_ready  output  1  loader accepts rx_data this cycle; a byte transfers when rx_valid && rx_ready.
REQ-009 load_req  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
REQ-010 mem_wren  output  1  instruction-memory write enable.
REQ-011 mem_addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-012 mem_data  output  32  instruction word to write.
REQ-013 core_reset  output  1  holds the core in reset while high.
REQ-014 done  output  1  program loaded and checksum good.
REQ-015 err  output  1  frame rejected.

Function
REQ-016 The frame SHALL be: SYNC_BYTE, LEN (word count), LEN×4 payload bytes (little-endian per word, so the first byte goes to bits 7:0), then CSUM (XOR of all payload bytes).
REQ-017 The FSM SHALL have states IDLE, GET_LEN, GET_DATA, WRITE, GET_CSUM, DONE, ERROR.
REQ-018 IDLE: rx_ready=1. A byte equal to SYNC_BYTE SHALL move to GET_LEN. Any other byte SHALL be discarded, and the FSM SHALL stay in IDLE.
REQ-019 GET_LEN: rx_ready=1. LEN=0 or LEN>DEPTH SHALL go to ERROR. Otherwise the FSM SHALL latch LEN, clear the word index and byte count, and go to GET_DATA.
REQ-020 GET_DATA: rx_ready=1. Each accepted byte SHALL be shifted into a 32-bit assembly register and XORed into the running checksum. The 4th byte SHALL go to WRITE.
REQ-021 WRITE SHALL last exactly one cycle with rx_ready=0, mem_wren=1, mem_addr=word index, and mem_data=assembled word.
REQ-022 After WRITE, the word index SHALL increment and the byte count SHALL clear. If the word index equals LEN-1, the next state SHALL be GET_CSUM; otherwise it SHALL be GET_DATA.
REQ-023 GET_CSUM: rx_ready=1. A byte equal to the running checksum SHALL go to DONE; any other byte SHALL go to ERROR.
REQ-024 DONE: core_reset=0, done=1, rx_ready=0. load_req SHALL go to IDLE.
REQ-025 ERROR: core_reset=1, err=1, rx_ready=0. load_req SHALL go to IDLE.
REQ-026 core_reset SHALL be 1 in every state except DONE.
REQ-027 mem_wren SHALL be 0 outside WRITE, and exactly one write SHALL occur per word.
REQ-028 Words written before an ERROR SHALL NOT be rolled back.
REQ-029 load_req in any state other than DONE or ERROR SHALL be ignored.
REQ-030 In ERROR and DONE, rx_valid SHALL be ignored and no bytes consumed.
REQ-031 A LEN of DEPTH SHALL write addresses 0..DEPTH-1 with no wrap.
REQ-032 done and err SHALL change only on state transitions, never in the same cycle as a byte acceptance.

Reset
REQ-033 On reset the block SHALL enter IDLE, clear all counters, the checksum and the assembly register, and drive core_reset=1, rx_ready=0 (this cycle), mem_wren=0, mem_addr=0, mem_data=0, done=0, err=0.
REQ-034 A reset asserted mid-frame SHALL abort the frame, issue no further memory writes, and accept a new frame starting with SYNC_BYTE.

Structure
REQ-035 Package imem_loader_pkg SHALL hold the state enum, SYNC_BYTE, DEPTH and ADDR_WIDTH.
REQ-036 Sub-module word_packer SHALL contain the byte counter, the little-endian assembly register and the word-complete flag.
REQ-037 The FSM, word index, LEN register and checksum SHALL live in imem_loader.

Verification
REQ-038 Scenario: send A5, 01, 13 00 00 00, 13 -> one write at addr 0 with data 0x00000013; then done=1 and core_reset=0.
REQ-039 Scenario: send 3 words with the correct CSUM -> writes at addrs 0,1,2 in order, each mem_wren one cycle, and rx_ready=0 during each WRITE.
REQ-040 Scenario: send A5, 02, 8 payload bytes, wrong CSUM -> err=1, core_reset stays 1, then a load_req pulse returns the FSM to IDLE.
REQ-041 Scenario: send FF, 00, A5, 00 -> the first two bytes are discarded, LEN=0 goes to ERROR, and no write occurs.
REQ-042 Scenario: send LEN=128 with a full payload and rx_valid toggling randomly -> 128 writes to addrs 0..127 and done=1; LEN=129 -> ERROR.
REQ-043 Scenario: assert reset after the 2nd payload byte -> no write occurs, and a following valid 1-word frame loads correctly to addr 0.
